exu_alu_pipe: RTL and testbench

EXU_ALU_PIPE -- requirements
Module: exu_alu_pipe

---
 rtl/mercury_pkg.sv | 19 +
 rtl/exu_alu_core.sv | 62 ++++++
 rtl/exu_alu_pipe.sv | 130 +++++++++++++
 tb/tb_exu_alu_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mercury_pkg.sv
// Shared ALU definitions for the execution unit: operation encodings and their width.
package mercury_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

endpackage

// File: rtl/exu_alu_core.sv
// Purely combinational integer ALU datapath; supports RV64-style 32-bit word ops when XLEN=64.
module exu_alu_core
    import mercury_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  alu_op_t         alu_op,
    input  logic            alu_word,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] result
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] sh;
    logic [31:0]     a_w;
    logic [31:0]     b_w;
    logic [4:0]      sh_w;
    logic [31:0]     word_res;
    logic [63:0]     word_ext;
    logic            use_word;

    assign sh       = operand_b[SH_W-1:0];
    assign a_w      = operand_a[31:0];
    assign b_w      = operand_b[31:0];
    assign sh_w     = operand_b[4:0];
    assign use_word = alu_word && (XLEN == 64);

    // Word variants compute on the low half, then sign-extend bit 31.
    always_comb begin
        word_res = '0;
        case (alu_op)
            ALU_ADD: word_res = a_w + b_w;
            ALU_SUB: word_res = a_w - b_w;
            ALU_SLL: word_res = a_w << sh_w;
            ALU_SRL: word_res = a_w >> sh_w;
            ALU_SRA: word_res = $unsigned($signed(a_w) >>> sh_w);
            default: word_res = '0;
        endcase
        word_ext = {{32{word_res[31]}}, word_res};
    end

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = use_word ? word_ext[XLEN-1:0] : operand_a + operand_b;
            ALU_SUB:  result = use_word ? word_ext[XLEN-1:0] : operand_a - operand_b;
            ALU_AND:  result = operand_a & operand_b;
            ALU_OR:   result = operand_a | operand_b;
            ALU_XOR:  result = operand_a ^ operand_b;
            ALU_SLL:  result = use_word ? word_ext[XLEN-1:0] : operand_a << sh;
            ALU_SRL:  result = use_word ? word_ext[XLEN-1:0] : operand_a >> sh;
            ALU_SRA:  result = use_word ? word_ext[XLEN-1:0]
                                        : $unsigned($signed(operand_a) >>> sh);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/exu_alu_pipe.sv
// ALU pipeline stage with valid/ready handshakes, flush and synchronous reset.
// Define EXU_ALU_SKID_EN for a 2-entry output buffer with a registered s0_ready.
module exu_alu_pipe
    import mercury_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  alu_op_t          s0_alu_op,
    input  logic             s0_alu_word,
    input  logic [XLEN-1:0]  s0_alu_operandA,
    input  logic [XLEN-1:0]  s0_alu_operandB,
    input  logic [TAG_W-1:0] s0_tag,
    input  logic             flush,
    output logic             s1_valid,
    input  logic             s1_ready,
    output logic [XLEN-1:0]  s1_alu_result,
    output logic [TAG_W-1:0] s1_tag
);

    logic [XLEN-1:0] core_result;
    logic            s0_fire;
    logic            s1_fire;

    exu_alu_core #(
        .XLEN(XLEN)
    ) u_core (
        .alu_op    (s0_alu_op),
        .alu_word  (s0_alu_word),
        .operand_a (s0_alu_operandA),
        .operand_b (s0_alu_operandB),
        .result    (core_result)
    );

    assign s0_fire = s0_valid && s0_ready;
    assign s1_fire = s1_valid && s1_ready;

`ifdef EXU_ALU_SKID_EN

    // Entry 0 is always the head presented on s1; entry 1 only fills behind it.
    logic [1:0]       valid_q;
    logic [1:0]       valid_d;
    logic [XLEN-1:0]  result_q [2];
    logic [XLEN-1:0]  result_d [2];
    logic [TAG_W-1:0] tag_q    [2];
    logic [TAG_W-1:0] tag_d    [2];
    logic             ready_q;

    assign s0_ready      = ready_q && !rst;
    assign s1_valid      = valid_q[0];
    assign s1_alu_result = result_q[0];
    assign s1_tag        = tag_q[0];

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        tag_d    = tag_q;
        if (s1_fire) begin
            valid_d[0]  = valid_q[1];
            result_d[0] = result_q[1];
            tag_d[0]    = tag_q[1];
            valid_d[1]  = 1'b0;
        end
        if (s0_fire) begin
            if (!valid_d[0]) begin
                valid_d[0]  = 1'b1;
                result_d[0] = core_result;
                tag_d[0]    = s0_tag;
            end else begin
                valid_d[1]  = 1'b1;
                result_d[1] = core_result;
                tag_d[1]    = s0_tag;
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // ready_q looks at next-state occupancy so it never depends on s1_ready this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            result_q[0] <= '0;
            result_q[1] <= '0;
            tag_q[0]    <= '0;
            tag_q[1]    <= '0;
            ready_q     <= 1'b1;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            ready_q  <= !valid_d[1];
        end
    end

`else

    logic             valid_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;

    assign s0_ready      = !rst && (!valid_q || s1_ready);
    assign s1_valid      = valid_q;
    assign s1_alu_result = result_q;
    assign s1_tag        = tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (s0_fire) begin
            valid_q  <= 1'b1;
            result_q <= core_result;
            tag_q    <= s0_tag;
        end else if (s1_fire) begin
            valid_q <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_exu_alu_pipe.sv
// Directed self-checking bench for exu_alu_pipe (XLEN=64); covers ops, backpressure, flush and reset.
module tb_exu_alu_pipe;
    import mercury_pkg::*;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
`ifdef EXU_ALU_SKID_EN
    localparam int STALL_ACCEPT = 2;
`else
    localparam int STALL_ACCEPT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             s0_valid;
    logic             s0_ready;
    alu_op_t          s0_alu_op;
    logic             s0_alu_word;
    logic [XLEN-1:0]  s0_alu_operandA;
    logic [XLEN-1:0]  s0_alu_operandB;
    logic [TAG_W-1:0] s0_tag;
    logic             flush;
    logic             s1_valid;
    logic             s1_ready;
    logic [XLEN-1:0]  s1_alu_result;
    logic [TAG_W-1:0] s1_tag;

    int checks   = 0;
    int failures = 0;

    exu_alu_pipe #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s0_valid        (s0_valid),
        .s0_ready        (s0_ready),
        .s0_alu_op       (s0_alu_op),
        .s0_alu_word     (s0_alu_word),
        .s0_alu_operandA (s0_alu_operandA),
        .s0_alu_operandB (s0_alu_operandB),
        .s0_tag          (s0_tag),
        .flush           (flush),
        .s1_valid        (s1_valid),
        .s1_ready        (s1_ready),
        .s1_alu_result   (s1_alu_result),
        .s1_tag          (s1_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input alu_op_t op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [TAG_W-1:0] tag);
        s0_valid        = valid;
        s0_alu_op       = op;
        s0_alu_word     = word;
        s0_alu_operandA = a;
        s0_alu_operandB = b;
        s0_tag          = tag;
    endtask

    // Issue one request with s1_ready high and check it appears the next cycle.
    task automatic issueOne(input string name, input alu_op_t op, input logic word,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [TAG_W-1:0] tag, input logic [63:0] exp);
        applyStimulus(1'b1, op, word, a, b, tag);
        #1;
        checkOutput({name, " s0_ready"}, {63'b0, s0_ready}, 64'd1);
        @(posedge clk);
        #1;
        s0_valid = 1'b0;
        checkOutput({name, " s1_valid"}, {63'b0, s1_valid}, 64'd1);
        checkOutput({name, " result"}, s1_alu_result, exp);
        checkOutput({name, " tag"}, {59'b0, s1_tag}, {59'b0, tag});
    endtask

    logic fire;
    logic dout;
    logic [TAG_W-1:0] seen_tag;
    logic [63:0]      seen_res;
    int accepted;
    int delivered;
    int next_tag;
    int expect_tag;

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        s1_ready = 1'b1;
        applyStimulus(1'b0, ALU_ADD, 1'b0, 64'd0, 64'd0, 5'd0);

        // Reset
        @(posedge clk);
        #1;
        checkOutput("rst s0_ready", {63'b0, s0_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst s1_valid", {63'b0, s1_valid}, 64'd0);
        checkOutput("rst result", s1_alu_result, 64'd0);
        checkOutput("rst tag", {59'b0, s1_tag}, 64'd0);
        #1;
        checkOutput("post-rst s0_ready", {63'b0, s0_ready}, 64'd1);

        // Operation vectors, back-to-back with s1_ready high
        issueOne("sub 0-1",   ALU_SUB,  1'b0, 64'd0, 64'd1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        issueOne("addw ovf",  ALU_ADD,  1'b1, 64'h7FFF_FFFF, 64'd1, 5'd4, 64'hFFFF_FFFF_8000_0000);
        issueOne("sra",       ALU_SRA,  1'b0, 64'h8000_0000_0000_0000, 64'h43, 5'd5, 64'hF000_0000_0000_0000);
        issueOne("sraw",      ALU_SRA,  1'b1, 64'h8000_0000, 64'h43, 5'd6, 64'hFFFF_FFFF_F000_0000);
        issueOne("slt",       ALU_SLT,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7, 64'd1);
        issueOne("sltu",      ALU_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd8, 64'd0);
        issueOne("add wrap",  ALU_ADD,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd9, 64'd0);
        issueOne("and",       ALU_AND,  1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd10, 64'hF000_F000_F000_F000);
        issueOne("or",        ALU_OR,   1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd11, 64'hFFF0_FFF0_FFF0_FFF0);
        issueOne("xorw",      ALU_XOR,  1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd12, 64'h0FF0_0FF0_0FF0_0FF0);
        issueOne("sll 63",    ALU_SLL,  1'b0, 64'd1, 64'h13F, 5'd13, 64'h8000_0000_0000_0000);
        issueOne("srl",       ALU_SRL,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd14, 64'h0800_0000_0000_0000);
        issueOne("sllw",      ALU_SLL,  1'b1, 64'd1, 64'd31, 5'd15, 64'hFFFF_FFFF_8000_0000);
        issueOne("srlw",      ALU_SRL,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 5'd16, 64'h0000_0000_0800_0000);
        issueOne("subw",      ALU_SUB,  1'b1, 64'd0, 64'd1, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF);
        issueOne("undef op",  alu_op_t'(4'd12), 1'b0, 64'd5, 64'd3, 5'd18, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("idle s1_valid", {63'b0, s1_valid}, 64'd0);

        // Backpressure: five stalled cycles while offering tags 1..3
        s1_ready = 1'b0;
        accepted = 0;
        next_tag = 1;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(next_tag <= 3, ALU_ADD, 1'b0, 64'(next_tag), 64'd0, 5'(next_tag));
            #1;
            fire = s0_valid && s0_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                accepted++;
                next_tag++;
            end
            checkOutput("stall s1_valid", {63'b0, s1_valid}, 64'd1);
            checkOutput("stall tag", {59'b0, s1_tag}, 64'd1);
            checkOutput("stall result", s1_alu_result, 64'd1);
        end
        checkOutput("stall accepted", 64'(accepted), 64'(STALL_ACCEPT));
        checkOutput("stall s0_ready", {63'b0, s0_ready}, 64'd0);

        s1_ready   = 1'b1;
        delivered  = 0;
        expect_tag = 1;
        for (int c = 0; c < 20 && delivered < 3; c++) begin
            applyStimulus(next_tag <= 3, ALU_ADD, 1'b0, 64'(next_tag), 64'd0, 5'(next_tag));
            #1;
            fire     = s0_valid && s0_ready;
            dout     = s1_valid && s1_ready;
            seen_tag = s1_tag;
            seen_res = s1_alu_result;
            @(posedge clk);
            #1;
            if (fire) next_tag++;
            if (dout) begin
                checkOutput("drain tag", {59'b0, seen_tag}, 64'(expect_tag));
                checkOutput("drain result", seen_res, 64'(expect_tag));
                expect_tag++;
                delivered++;
            end
        end
        s0_valid = 1'b0;
        checkOutput("drain count", 64'(delivered), 64'd3);
        #1;
        checkOutput("drain empty", {63'b0, s1_valid}, 64'd0);

        // Flush with a buffered backlog and a same-cycle request (tag 7)
        s1_ready = 1'b0;
        next_tag = 4;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(next_tag <= 5, ALU_ADD, 1'b0, 64'(next_tag), 64'd0, 5'(next_tag));
            #1;
            fire = s0_valid && s0_ready;
            @(posedge clk);
            #1;
            if (fire) next_tag++;
        end
        checkOutput("pre-flush accepted", 64'(next_tag - 4), 64'(STALL_ACCEPT));
        checkOutput("pre-flush tag", {59'b0, s1_tag}, 64'd4);
        applyStimulus(1'b1, ALU_ADD, 1'b0, 64'd7, 64'd0, 5'd7);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        s0_valid = 1'b0;
        checkOutput("flush s1_valid", {63'b0, s1_valid}, 64'd0);
        s1_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("post-flush s1_valid", {63'b0, s1_valid}, 64'd0);
        end
        checkOutput("post-flush s0_ready", {63'b0, s0_ready}, 64'd1);

        // Reset mid-stream with a result pending
        s1_ready = 1'b0;
        applyStimulus(1'b1, ALU_ADD, 1'b0, 64'd1, 64'd1, 5'd9);
        @(posedge clk);
        #1;
        s0_valid = 1'b0;
        checkOutput("pre-rst s1_valid", {63'b0, s1_valid}, 64'd1);
        checkOutput("pre-rst tag", {59'b0, s1_tag}, 64'd9);
        rst = 1'b1;
        #1;
        checkOutput("mid-rst s0_ready", {63'b0, s0_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid-rst s1_valid", {63'b0, s1_valid}, 64'd0);
        checkOutput("mid-rst result", s1_alu_result, 64'd0);
        checkOutput("mid-rst tag", {59'b0, s1_tag}, 64'd0);
        s1_ready = 1'b1;
        issueOne("after rst", ALU_ADD, 1'b0, 64'd2, 64'd3, 5'd10, 64'd5);
        @(posedge clk);
        #1;
        checkOutput("final empty", {63'b0, s1_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
